// File: rtl/amp_pkg.sv
// Shared types and helpers for the PWM amplifier voice driver.
package amp_pkg;

  typedef enum logic [1:0] {OFF, WAKE, RUN, MUTE} amp_state_e;

  localparam int PWM_W_DEF = 8;
  localparam int PWM_MAX   = (1 << PWM_W_DEF) - 1;

  function automatic int unsigned sat_mul(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_val);
    int unsigned p;
    p = a * b;
    return (p > max_val) ? max_val : p;
  endfunction

endpackage

// File: rtl/amp_voice_driver_if.sv
// Key-decoder side controls and amplifier pins of the voice driver.
interface amp_voice_driver_if #(
  parameter int NUM_VOICES = 4,
  parameter int DIV_W      = 20,
  parameter int VOL_W      = 4
);
  logic [NUM_VOICES-1:0]       voice_en;
  logic [NUM_VOICES*DIV_W-1:0] voice_div;
  logic [VOL_W-1:0]            volume;
  logic                        gain_sel;
  logic                        amp_enable;
  logic                        ready;
  logic                        AIN;
  logic                        GAIN;
  logic                        NC;
  logic                        ACTIVE;

  modport master (
    output voice_en, voice_div, volume, gain_sel, amp_enable,
    input  ready, AIN, GAIN, NC, ACTIVE
  );

  modport slave (
    input  voice_en, voice_div, volume, gain_sel, amp_enable,
    output ready, AIN, GAIN, NC, ACTIVE
  );
endinterface

// File: rtl/amp_voice_osc.sv
// Square-wave tone oscillator: toggles sq every div cycles (period 2*div).
module amp_voice_osc #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sq
);

  logic [DIV_W-1:0] cnt;

  // >= so a divider lowered mid-count wraps on the next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (!en || div == '0) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt >= div - 1'b1) begin
      cnt <= '0;
      sq  <= ~sq;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/amp_voice_driver.sv
// Tone mixer, PWM modulator and amplifier power sequencer.
// Define SOFT_MUTE_EN to ramp the volume down in MUTE instead of a 1-cycle cut.
module amp_voice_driver
  import amp_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int DIV_W       = 20,
  parameter int VOL_W       = 4,
  parameter int PWM_W       = PWM_W_DEF,
  parameter int WAKE_CYCLES = 1000,
  parameter int RAMP_DIV    = 256
) (
  input  logic              clk,
  input  logic              rst,
  amp_voice_driver_if.slave bus
);

  localparam int NSUM_W  = $clog2(NUM_VOICES + 1);
  localparam int LVL_MAX = (1 << PWM_W) - 1;
  localparam int WAKE_W  = $clog2(WAKE_CYCLES + 1);

  amp_state_e              state, state_nxt;
  logic [WAKE_W-1:0]       wake_cnt, wake_nxt;
  logic [VOL_W-1:0]        vol_eff, vol_nxt, vol_use;
  logic [NUM_VOICES-1:0]   sq_p0;
  logic [NSUM_W-1:0]       nsum_p0;
  logic [PWM_W-1:0]        level_p0;
  logic [PWM_W-1:0]        duty_p1, duty_eff;
  logic [PWM_W-1:0]        pwm_cnt;
  logic                    ain_p2;
  logic                    gain_q;

  // Stage 0: oscillators and mixer
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    amp_voice_osc #(.DIV_W(DIV_W)) u_osc (
      .clk (clk),
      .rst (rst),
      .en  (bus.voice_en[i]),
      .div (bus.voice_div[i*DIV_W +: DIV_W]),
      .sq  (sq_p0[i])
    );
  end

  assign vol_use  = (state == RUN) ? bus.volume : vol_eff;
  assign nsum_p0  = NSUM_W'($countones(sq_p0));
  assign level_p0 = PWM_W'(sat_mul(32'(nsum_p0), 32'(vol_use), 32'(LVL_MAX)));

`ifdef SOFT_MUTE_EN
  localparam int RAMP_W = $clog2(RAMP_DIV + 1);
  logic [RAMP_W-1:0] ramp_cnt, ramp_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ramp_cnt <= '0;
    else     ramp_cnt <= ramp_nxt;
  end

  assign duty_eff = duty_p1;
`else
  logic unused_ramp;
  assign unused_ramp = (RAMP_DIV > 0);
  assign duty_eff    = (state == MUTE) ? '0 : duty_p1;
`endif

  // Stage 1: duty latched only at frame end; stage 2: registered AIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_p1 <= '0;
      ain_p2  <= 1'b0;
      gain_q  <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (&pwm_cnt) duty_p1 <= level_p0;
      ain_p2  <= (state == RUN || state == MUTE) && (pwm_cnt < duty_eff);
      if (state == OFF) gain_q <= bus.gain_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      wake_cnt <= '0;
      vol_eff  <= '0;
    end else begin
      state    <= state_nxt;
      wake_cnt <= wake_nxt;
      vol_eff  <= vol_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wake_nxt  = wake_cnt;
    vol_nxt   = vol_eff;
`ifdef SOFT_MUTE_EN
    ramp_nxt  = ramp_cnt;
`endif
    unique case (state)
      OFF: begin
        vol_nxt = '0;
        if (bus.amp_enable) begin
          state_nxt = WAKE;
          wake_nxt  = '0;
        end
      end
      WAKE: begin
        if (!bus.amp_enable)                            state_nxt = OFF;
        else if (wake_cnt == WAKE_W'(WAKE_CYCLES - 1))  state_nxt = RUN;
        else                                            wake_nxt  = wake_cnt + 1'b1;
      end
      RUN: begin
        vol_nxt = bus.volume;
        if (!bus.amp_enable) begin
          state_nxt = MUTE;
`ifdef SOFT_MUTE_EN
          ramp_nxt  = '0;
`endif
        end
      end
      MUTE: begin
        // A reasserted enable outranks ramp completion
        if (bus.amp_enable) begin
          state_nxt = RUN;
          vol_nxt   = bus.volume;
        end
`ifdef SOFT_MUTE_EN
        else if (vol_eff == '0) begin
          state_nxt = OFF;
        end else if (ramp_cnt == RAMP_W'(RAMP_DIV - 1)) begin
          ramp_nxt = '0;
          vol_nxt  = vol_eff - 1'b1;
          if (vol_eff == VOL_W'(1)) state_nxt = OFF;
        end else begin
          ramp_nxt = ramp_cnt + 1'b1;
        end
`else
        else begin
          state_nxt = OFF;
          vol_nxt   = '0;
        end
`endif
      end
      default: state_nxt = OFF;
    endcase
  end

  assign bus.AIN    = ain_p2;
  assign bus.GAIN   = gain_q;
  assign bus.NC     = 1'b0;
  assign bus.ACTIVE = (state != OFF);
  assign bus.ready  = (state == RUN);

endmodule

// File: tb/tb_amp_voice_driver.sv
// Randomized self-checking bench for amp_voice_driver against a frame-level tone/PWM model.
module tb_amp_voice_driver;
  import amp_pkg::*;

  localparam int FRAME = PWM_MAX + 1;
`ifdef SOFT_MUTE_EN
  localparam int MUTE_LEN = 32;
  localparam int REASSERT = 10;
`else
  localparam int MUTE_LEN = 1;
  localparam int REASSERT = 1;
`endif

  logic clk;
  logic rst;
  amp_voice_driver_if bus ();

  amp_voice_driver #(
    .WAKE_CYCLES (16),
    .RAMP_DIV    (4),
    .PWM_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int edges;
  logic [3:0] cfg_en;
  int cfg_div [4];
  int cfg_start;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges since reset release; equals the free-running PWM position.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Restart all voices from count 0 with a new configuration.
  task automatic apply_voices(input logic [3:0] en, input int d0, input int d1,
                              input int d2, input int d3);
    bus.voice_en = '0;
    step();
    cfg_en    = en;
    cfg_div   = '{d0, d1, d2, d3};
    cfg_start = edges;
    bus.voice_div = {20'(d3), 20'(d2), 20'(d1), 20'(d0)};
    bus.voice_en  = en;
  endtask

  // A voice with half period d is high during the odd d-sized spans since start.
  function automatic int model_level(input int m, input int vol);
    int n = 0;
    int lvl;
    for (int i = 0; i < 4; i++)
      if (cfg_en[i] && cfg_div[i] != 0 && (((m - cfg_start) / cfg_div[i]) % 2) == 1)
        n++;
    lvl = n * vol;
    return (lvl > PWM_MAX) ? PWM_MAX : lvl;
  endfunction

  // Observe one whole PWM frame; bad counts cycles whose AIN differs from pos<duty.
  task automatic run_frame(output int bad, output int hi, output int expd);
    while (edges % FRAME != FRAME - 1) step();
    expd = model_level(edges, int'(bus.volume));
    step();
    bad = 0;
    hi  = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (bus.AIN !== 1'(k < expd)) bad++;
      if (bus.AIN === 1'b1) hi++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.amp_enable = 1'b0;
    bus.gain_sel   = 1'b0;
    bus.volume     = '0;
    bus.voice_en   = '0;
    bus.voice_div  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.AIN !== 1'b0)    begin errors++; $display("FAIL reset_AIN: got %b expected 0", bus.AIN); end
    checks++; if (bus.ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_ACTIVE: got %b expected 0", bus.ACTIVE); end
    checks++; if (bus.ready !== 1'b0)  begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.GAIN !== 1'b1)   begin errors++; $display("FAIL reset_GAIN: got %b expected 1", bus.GAIN); end
    checks++; if (bus.NC !== 1'b0)     begin errors++; $display("FAIL reset_NC: got %b expected 0", bus.NC); end
  endtask

  task automatic test_powerup();
    int guard = 0;
    int ain_bad = 0;
    rst = 1'b0;
    bus.amp_enable = 1'b1;
    step();
    checks++; if (bus.ACTIVE !== 1'b1 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL powerup_active: got ACTIVE=%b ready=%b expected 1/0", bus.ACTIVE, bus.ready);
    end
    checks++; if (bus.GAIN !== 1'b0) begin errors++; $display("FAIL powerup_gain_sample: got %b expected 0", bus.GAIN); end
    bus.gain_sel = 1'b1;
    while (bus.ready !== 1'b1 && guard < 100) begin
      step();
      guard++;
      if (bus.AIN !== 1'b0) ain_bad++;
    end
    checks++; if (edges - 1 !== 16) begin errors++; $display("FAIL powerup_wake_len: got %0d expected 16", edges - 1); end
    checks++; if (ain_bad !== 0) begin errors++; $display("FAIL powerup_ain_quiet: got %0d high cycles expected 0", ain_bad); end
    checks++; if (bus.GAIN !== 1'b0) begin errors++; $display("FAIL powerup_gain_hold: got %b expected 0", bus.GAIN); end
    bus.gain_sel = 1'b0;
  endtask

  task automatic test_tone();
    int bad, hi, expd, sq_bad;
    bus.volume = 4'd15;
    apply_voices(4'b0001, 5, 0, 0, 0);
    sq_bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (dut.sq_p0[0] !== 1'(((edges - cfg_start) / 5) % 2)) sq_bad++;
    end
    checks++; if (sq_bad !== 0) begin errors++; $display("FAIL tone_period: got %0d bad cycles expected 0", sq_bad); end
    for (int f = 0; f < 2; f++) begin
      run_frame(bad, hi, expd);
      checks++; if (bad !== 0 || hi !== expd) begin
        errors++; $display("FAIL tone_frame%0d: got %0d high (%0d bad) expected %0d", f, hi, bad, expd);
      end
    end
  endtask

  task automatic test_saturation();
    int bad, hi, expd, sq_bad;
    int d = int'($urandom_range(600, 900));
    bus.volume = 4'd15;
    apply_voices(4'b1111, d, d, d, d);
    repeat (d) step();
    run_frame(bad, hi, expd);
    checks++; if (bad !== 0 || hi !== 60) begin
      errors++; $display("FAIL sat_all_high: got %0d high (%0d bad) expected 60", hi, bad);
    end
    apply_voices(4'b1111, d, d, 0, d);
    sq_bad = 0;
    for (int k = 0; k < d; k++) begin
      step();
      if (dut.sq_p0[2] !== 1'b0) sq_bad++;
    end
    checks++; if (sq_bad !== 0) begin errors++; $display("FAIL div0_sq_held: got %0d high cycles expected 0", sq_bad); end
    run_frame(bad, hi, expd);
    checks++; if (bad !== 0 || hi !== 45) begin
      errors++; $display("FAIL div0_frame: got %0d high (%0d bad) expected 45", hi, bad);
    end
  endtask

  task automatic test_frame_boundary();
    int b1, h1, e1, b2, h2, e2;
    int off = int'($urandom_range(10, 200));
    bus.volume = 4'd3;
    apply_voices(4'b1111, 1500, 1500, 1500, 1500);
    repeat (1500) step();
    while (edges % FRAME != 200) step();
    fork
      run_frame(b1, h1, e1);
      begin
        repeat (56 + off) step();
        bus.volume = 4'd9;
      end
    join
    checks++; if (b1 !== 0 || h1 !== 12) begin
      errors++; $display("FAIL frame_hold: got %0d high (%0d bad) expected 12", h1, b1);
    end
    run_frame(b2, h2, e2);
    checks++; if (b2 !== 0 || h2 !== 36) begin
      errors++; $display("FAIL frame_next: got %0d high (%0d bad) expected 36", h2, b2);
    end
  endtask

  task automatic test_random();
    int bad, hi, expd;
    for (int it = 0; it < 3; it++) begin
      bus.volume = 4'($urandom_range(0, 15));
      apply_voices(4'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
      run_frame(bad, hi, expd);
      checks++; if (bad !== 0 || hi !== expd) begin
        errors++; $display("FAIL random%0d: got %0d high (%0d bad) expected %0d", it, hi, bad, expd);
      end
    end
  endtask

  task automatic test_mute();
    int bad, hi, expd;
    int cnt = 0;
    int guard = 0;
    bus.volume = 4'd8;
    apply_voices(4'b1111, 3000, 3000, 3000, 3000);
    repeat (3000) step();
    while (edges % FRAME != 4) step();
    bus.amp_enable = 1'b0;
    while (bus.ACTIVE === 1'b1 && guard < 200) begin
      step();
      guard++;
      if (bus.ACTIVE === 1'b1 && bus.ready === 1'b0) cnt++;
    end
    checks++; if (cnt !== MUTE_LEN || bus.ACTIVE !== 1'b0) begin
      errors++; $display("FAIL mute_len: got %0d cycles (ACTIVE=%b) expected %0d", cnt, bus.ACTIVE, MUTE_LEN);
    end
`ifndef SOFT_MUTE_EN
    checks++; if (bus.AIN !== 1'b0) begin errors++; $display("FAIL mute_duty_zero: got %b expected 0", bus.AIN); end
`endif
    bus.amp_enable = 1'b1;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL mute_rewake: got %b expected 1", bus.ready); end
    bus.amp_enable = 1'b0;
    repeat (REASSERT) step();
    bus.amp_enable = 1'b1;
    step();
    checks++; if (bus.ready !== 1'b1 || bus.ACTIVE !== 1'b1) begin
      errors++; $display("FAIL mute_reassert: got ready=%b ACTIVE=%b expected 1/1", bus.ready, bus.ACTIVE);
    end
    run_frame(bad, hi, expd);
    checks++; if (bad !== 0 || hi !== 32) begin
      errors++; $display("FAIL mute_restore: got %0d high (%0d bad) expected 32", hi, bad);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    bus.volume = 4'd15;
    while (bus.AIN !== 1'b1 && guard < 600) begin
      step();
      guard++;
    end
    checks++; if (bus.AIN !== 1'b1) begin errors++; $display("FAIL areset_ain_seen: got %b expected 1", bus.AIN); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.AIN !== 1'b0 || bus.ACTIVE !== 1'b0 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL areset_outputs: got AIN=%b ACTIVE=%b ready=%b expected 0/0/0", bus.AIN, bus.ACTIVE, bus.ready);
    end
    checks++; if (bus.GAIN !== 1'b1) begin errors++; $display("FAIL areset_GAIN: got %b expected 1", bus.GAIN); end
    checks++; if (dut.sq_p0 !== 4'b0000) begin errors++; $display("FAIL areset_voices: got %b expected 0000", dut.sq_p0); end
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_tone();
    test_saturation();
    test_frame_boundary();
    test_random();
    test_mute();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
